// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage controller that turns 32-bit loads/stores into two
// 16-bit SRAM half-accesses (low half, then high half), each held for
// WAIT_CYCLES cycles, and stalls the pipeline until the access completes.
//
// Optional feature: define SRAM_READ_CACHE_EN to compile in a one-entry read
// cache (valid, word tag, data) that answers repeated loads in zero cycles.
//
// Parameters:
//   WAIT_CYCLES  cycles each half-access is held (2..15)
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   wr_en        store request
//   rd_en        load request (ignored when wr_en is also high)
//   address      byte address; SRAM window starts at byte 1024
//   write_data   store data
//   read_data    load result, valid while ready=1 after a read
//   ready        access complete / controller free
//   freeze       pipeline stall = (rd_en|wr_en) & ~ready
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_in   SRAM read data
//   sram_dq_oe   drive enable for sram_dq_out
//   sram_we_n    SRAM write strobe, active-low
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 17;
  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                op_wr_q;
  logic [WORD_W-1:0]   word_q;
  logic [31:0]         wdata_q;
  logic [31:0]         read_data_q;
  logic [17:0]         sram_addr_q;
  logic [15:0]         sram_dq_out_q;
  logic                sram_dq_oe_q;
  logic                sram_we_n_q;

  logic [31:0]         eff_c;
  logic [WORD_W-1:0]   word_c;
  logic                req_c;
  logic                last_c;
  logic                hold_end_c;
  logic                cache_hit_c;
  logic                unused_eff_c;

  // Address translation into the SRAM word space
  assign eff_c        = address - BASE_ADDR;
  assign word_c       = eff_c[18:2];
  assign unused_eff_c = ^{eff_c[31:19], eff_c[1:0]};

  assign req_c      = wr_en | rd_en;
  assign last_c     = (cnt_q == CNT_LAST);
  // Next cycle is the last of the phase: release we_n so data is held past it
  assign hold_end_c = ((cnt_q + CNT_W'(1)) == CNT_LAST);

`ifdef SRAM_READ_CACHE_EN
  logic              cache_vld_q;
  logic [WORD_W-1:0] cache_tag_q;
  logic [31:0]       cache_data_q;

  // A simultaneous write wins, so only a pure load may hit
  assign cache_hit_c = (state_q == S_IDLE) & rd_en & ~wr_en & cache_vld_q &
                       (cache_tag_q == word_c);

  // Fill on read completion, keep coherent on a matching write completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_tag_q  <= '0;
      cache_data_q <= '0;
    end else if (state_q == S_DONE) begin
      if (!op_wr_q) begin
        cache_vld_q  <= 1'b1;
        cache_tag_q  <= word_q;
        cache_data_q <= read_data_q;
      end else if (cache_vld_q && (cache_tag_q == word_q)) begin
        cache_data_q <= wdata_q;
      end
    end
  end

  assign read_data = cache_hit_c ? cache_data_q : read_data_q;
`else
  assign cache_hit_c = 1'b0;
  assign read_data   = read_data_q;
`endif

  assign ready  = (state_q == S_DONE) |
                  ((state_q == S_IDLE) & (~req_c | cache_hit_c));
  assign freeze = req_c & ~ready;

  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

  // Access sequencer; SRAM pins are registered and set up one edge ahead
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_c && !cache_hit_c) begin
            state_q     <= S_LOW;
            cnt_q       <= '0;
            op_wr_q     <= wr_en;
            word_q      <= word_c;
            wdata_q     <= write_data;
            sram_addr_q <= {word_c, 1'b0};
            if (wr_en) begin
              sram_dq_out_q <= write_data[15:0];
              sram_dq_oe_q  <= 1'b1;
              sram_we_n_q   <= 1'b0;
            end else begin
              sram_dq_oe_q  <= 1'b0;
              sram_we_n_q   <= 1'b1;
            end
          end
        end

        S_LOW: begin
          if (last_c) begin
            state_q     <= S_HIGH;
            cnt_q       <= '0;
            sram_addr_q <= {word_q, 1'b1};
            if (op_wr_q) begin
              sram_dq_out_q <= wdata_q[31:16];
              sram_we_n_q   <= 1'b0;
            end else begin
              read_data_q[15:0] <= sram_dq_in;
            end
          end else begin
            cnt_q       <= cnt_q + CNT_W'(1);
            sram_we_n_q <= ~op_wr_q | hold_end_c;
          end
        end

        S_HIGH: begin
          if (last_c) begin
            state_q      <= S_DONE;
            cnt_q        <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            if (!op_wr_q) begin
              read_data_q[31:16] <= sram_dq_in;
            end
          end else begin
            cnt_q       <= cnt_q + CNT_W'(1);
            sram_we_n_q <= ~op_wr_q | hold_end_c;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
